divider_arbiter: RTL and testbench
==================================

Name: divider_arbiter

Overview:
- Sequences and shares one Newton-Raphson `divider` instance (Q16.16 in, Q4.28 out) between NUM_REQ requesters.
- Arbitrates round-robin, latches operands, issues the operation and returns the tagged result on one response bus.
- Recycles the divider after every operation with a one-cycle `div_rst` pulse, because the divider never leaves its DONE state on its own.
- Bypasses the divider for divide-by-zero, which would otherwise hang it in SHIFT.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 32, operand/result width; must equal divider I_WIDTH+F_WIDTH.
- ID_WIDTH, $clog2(NUM_REQ), width of resp_id.
- TIMEOUT_CYCLES, 64, watchdog limit in WAIT (used only with DIV_TIMEOUT_EN).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  one-hot grant/accept.
- req_N  in  NUM_REQ*DATA_WIDTH  dividends, requester i at bits [i*DATA_WIDTH +: DATA_WIDTH], signed Q16.16.
- req_D  in  NUM_REQ*DATA_WIDTH  divisors, same packing.
- resp_valid  out  1  result valid.
- resp_ready  in  1  result consumed.
- resp_data  out  DATA_WIDTH  quotient, signed Q4.28.
- resp_id  out  ID_WIDTH  index of the requester that owns resp_data.
- resp_dz  out  1  divide-by-zero flag.
- resp_err  out  1  timeout flag; constant 0 without DIV_TIMEOUT_EN.
- div_N, div_D  out  DATA_WIDTH each  operands to divider N_in/D_in.
- div_in_valid  out  1  to divider in_valid.
- div_rst  out  1  to divider rst (synchronous, active-high).
- div_ready, div_out_valid  in  1 each  from divider.
- div_out  in  DATA_WIDTH  from divider out.

Behaviour:
Reset:
- While rst=0: state=IDLE, rr_ptr=0, req_ready=0, div_in_valid=0, div_N=div_D=0, resp_valid=0, resp_data=0, resp_id=0, resp_dz=0, resp_err=0.
- While rst=0, div_rst=1, so the divider is held reset for the whole reset period.
- Reset mid-operation abandons the transaction. No response is produced for it.

States: IDLE, ISSUE, WAIT, RESP, FLUSH.

IDLE:
- Grant g is the first i with req_valid[i]=1, searching from rr_ptr upward with wrap-around.
- req_ready[g]=1 combinationally, only if div_ready=1. All other req_ready bits are 0.
- On handshake: latch N, D and id; set rr_ptr=(g+1) mod NUM_REQ.
- If latched D==0: go to RESP with resp_data=32'h7FFF_FFFF when N>=0, 32'h8000_0000 when N<0, and resp_dz=1. The divider is never started.
- Otherwise go to ISSUE.
- No request, or div_ready=0: stay in IDLE with all req_ready=0.

ISSUE:
- div_in_valid=1 for exactly one cycle; div_N/div_D hold the latched operands.
- Next state is WAIT.

WAIT:
- div_in_valid=0.
- On div_out_valid=1: capture div_out into resp_data, set resp_dz=0, resp_err=0, go to RESP.

RESP:
- resp_valid=1; resp_data, resp_id and the flags are stable until resp_valid&resp_ready.
- On that handshake: resp_valid=0 in the next cycle and the state goes to FLUSH.
- Returning straight to IDLE from RESP is allowed only for the divide-by-zero bypass, which has nothing to flush.

FLUSH:
- div_rst=1 for exactly one cycle, then IDLE.
- The divider then reports ready in the following cycle. IDLE must not grant until div_ready=1.

Other rules:
- div_rst=0 in every state except FLUSH (and during reset).
- Only one operation is ever outstanding; new requests wait in IDLE.
- A requester may drop req_valid before it is granted; there is no penalty.
- Latency, accept to resp_valid = 1 (ISSUE) + divider latency + 1.
- Throughput: one operation per divider latency + 4 cycles.
- Fairness: with all requesters valid, no requester waits more than NUM_REQ-1 grants.

Optional Feature:
- Macro: DIV_TIMEOUT_EN.
- Defined:
  - A counter is cleared on entry to WAIT and increments each cycle in WAIT.
  - Reaching TIMEOUT_CYCLES without div_out_valid goes to RESP with resp_data=0 and resp_err=1.
  - FLUSH then recovers the divider.
- Undefined:
  - No counter; WAIT waits indefinitely.
  - resp_err is tied to 0.

Test Plan:
- Single op: req 2 with N=32'h0006_0000, D=32'h0002_0000 -> one ISSUE pulse; resp_id=2; resp_data=32'h3000_0000 ±16 LSB; resp_dz=0; one div_rst pulse after the resp handshake.
- Round-robin: all four requesters held valid, each with N=32'h0001_0000, D=32'h0004_0000 -> grant order 0,1,2,3,0; each resp_data≈32'h0400_0000.
- Divide-by-zero: N=32'hFFFF_0000, D=0 -> resp_data=32'h8000_0000, resp_dz=1; div_in_valid never asserted; no div_rst pulse.
- Negative divisor and backpressure: N=32'h0003_0000, D=32'hFFFF_0000, resp_ready held 0 for 10 cycles -> resp_data≈32'hD000_0000 held stable with resp_valid=1 for all 10 cycles; no grant to other requesters during that time.
- Reset mid-operation: rst=0 for 2 cycles while in WAIT -> all outputs at reset values, div_rst=1 throughout; the next request completes correctly.
- With DIV_TIMEOUT_EN and a stub divider that never asserts out_valid -> resp_err=1 and resp_data=0 after 64 WAIT cycles, then a FLUSH pulse and a return to IDLE.

Source files
------------

// File: rtl/divider_arbiter.sv
// divider_arbiter: round-robin front end sharing one Newton-Raphson divider
// (Q16.16 operands, Q4.28 quotient) between NUM_REQ requesters.
// Divide-by-zero requests bypass the divider with a saturated result.
// After every divider operation the divider is recycled with a one-cycle div_rst.
// Optional feature macro: DIV_TIMEOUT_EN adds a WAIT watchdog that reports resp_err.
module divider_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ID_WIDTH       = $clog2(NUM_REQ),
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_N,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_D,
    output logic                             resp_valid,
    input  logic                             resp_ready,
    output logic [DATA_WIDTH-1:0]            resp_data,
    output logic [ID_WIDTH-1:0]              resp_id,
    output logic                             resp_dz,
    output logic                             resp_err,
    output logic [DATA_WIDTH-1:0]            div_N,
    output logic [DATA_WIDTH-1:0]            div_D,
    output logic                             div_in_valid,
    output logic                             div_rst,
    input  logic                             div_ready,
    input  logic                             div_out_valid,
    input  logic [DATA_WIDTH-1:0]            div_out
);

    localparam int unsigned MSB = DATA_WIDTH - 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP,
        ST_FLUSH
    } state_t;

    state_t                  state;
    logic [ID_WIDTH-1:0]     rr_ptr;
    logic [ID_WIDTH-1:0]     grant_idx;
    logic                    grant_found;
    logic                    accept_c;
    logic                    timeout_c;
    logic [DATA_WIDTH-1:0]   sel_n;
    logic [DATA_WIDTH-1:0]   sel_d;
    logic [ID_WIDTH-1:0]     next_ptr;

    // Elaboration-time parameter sanity
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("divider_arbiter: NUM_REQ must be 2..8");
    end
    if (DATA_WIDTH < 2) begin : g_bad_width
        $error("divider_arbiter: DATA_WIDTH too small");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("divider_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    // Requester index base+off, wrapped into 0..NUM_REQ-1
    function automatic logic [ID_WIDTH-1:0] wrap_idx(input logic [ID_WIDTH-1:0] base,
                                                     input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return ID_WIDTH'(s);
    endfunction

    // Round-robin search from rr_ptr upward; the closest valid requester wins
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int unsigned k = NUM_REQ; k > 0; k--) begin
            if (req_valid[wrap_idx(rr_ptr, k - 1)]) begin
                grant_found = 1'b1;
                grant_idx   = wrap_idx(rr_ptr, k - 1);
            end
        end
    end

    // Grant only in IDLE with a ready divider; operands of the granted requester
    always_comb begin
        accept_c  = (state == ST_IDLE) && div_ready && grant_found;
        req_ready = accept_c ? (NUM_REQ'(1) << grant_idx) : '0;
        sel_n     = req_N[32'(grant_idx) * DATA_WIDTH +: DATA_WIDTH];
        sel_d     = req_D[32'(grant_idx) * DATA_WIDTH +: DATA_WIDTH];
        next_ptr  = (grant_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_idx + ID_WIDTH'(1);
    end

`ifdef DIV_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] wd_cnt;

    assign timeout_c = (state == ST_WAIT) && !div_out_valid &&
                       (wd_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // WAIT watchdog and the timeout flag it reports with the response
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt   <= '0;
            resp_err <= 1'b0;
        end else begin
            if (state == ST_ISSUE) begin
                wd_cnt <= '0;
            end else if (state == ST_WAIT) begin
                wd_cnt <= wd_cnt + TO_W'(1);
            end
            if (timeout_c) begin
                resp_err <= 1'b1;
            end else if (accept_c || (state == ST_WAIT && div_out_valid)) begin
                resp_err <= 1'b0;
            end
        end
    end
`else
    assign timeout_c = 1'b0;
    assign resp_err  = 1'b0;
`endif

    // Transaction sequencer: grant, issue, wait, respond, recycle the divider
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            rr_ptr       <= '0;
            div_N        <= '0;
            div_D        <= '0;
            div_in_valid <= 1'b0;
            div_rst      <= 1'b1;
            resp_valid   <= 1'b0;
            resp_data    <= '0;
            resp_id      <= '0;
            resp_dz      <= 1'b0;
        end else begin
            div_in_valid <= 1'b0;
            div_rst      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept_c) begin
                        div_N   <= sel_n;
                        div_D   <= sel_d;
                        resp_id <= grant_idx;
                        rr_ptr  <= next_ptr;
                        if (sel_d == '0) begin
                            // Saturate toward the dividend's sign; divider never started
                            resp_data  <= {sel_n[MSB], {(DATA_WIDTH - 1){~sel_n[MSB]}}};
                            resp_dz    <= 1'b1;
                            resp_valid <= 1'b1;
                            state      <= ST_RESP;
                        end else begin
                            div_in_valid <= 1'b1;
                            state        <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (div_out_valid) begin
                        resp_data  <= div_out;
                        resp_dz    <= 1'b0;
                        resp_valid <= 1'b1;
                        state      <= ST_RESP;
                    end else if (timeout_c) begin
                        resp_data  <= '0;
                        resp_dz    <= 1'b0;
                        resp_valid <= 1'b1;
                        state      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        if (resp_dz) begin
                            state <= ST_IDLE;
                        end else begin
                            div_rst <= 1'b1;
                            state   <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider_arbiter.sv
// tb_divider_arbiter: scoreboard bench for divider_arbiter with a behavioural divider stub.
// Define DIV_TIMEOUT_EN for both files to exercise the watchdog with a hanging divider.
module tb_divider_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned IW = 2;

    typedef struct packed {
        logic [DW-1:0] n;
        logic [DW-1:0] d;
    } op_t;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
        logic          dz;
        logic          err;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NR-1:0]     req_valid = '0;
    logic [NR-1:0]     req_ready;
    logic [NR*DW-1:0]  req_N;
    logic [NR*DW-1:0]  req_D;
    logic              resp_valid;
    logic              resp_ready = 1'b1;
    logic [DW-1:0]     resp_data;
    logic [IW-1:0]     resp_id;
    logic              resp_dz;
    logic              resp_err;
    logic [DW-1:0]     div_N;
    logic [DW-1:0]     div_D;
    logic              div_in_valid;
    logic              div_rst;
    logic              dv_ready = 1'b0;
    logic              dv_ov = 1'b0;
    logic              dv_busy = 1'b0;
    logic [DW-1:0]     dv_out = '0;
    logic [DW-1:0]     dv_n = '0;
    logic [DW-1:0]     dv_d = '0;
    int                dv_cnt = 0;

    logic [DW-1:0]     rq_n [NR];
    logic [DW-1:0]     rq_d [NR];
    op_t               op_q [NR][$];
    exp_t              exp_q [$];
    int                grant_log [$];
    logic [NR-1:0]     hs_last = '0;
    bit                hold_bp = 1'b0;
    bit                rand_bp = 1'b0;
    bit                stub_hang = 1'b0;
    int                n_issue = 0;
    int                n_flush = 0;
    int                checks = 0;
    int                errors = 0;

    always #5 clk = ~clk;

    divider_arbiter #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .ID_WIDTH(IW), .TIMEOUT_CYCLES(64)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_N(req_N), .req_D(req_D),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_id(resp_id),
        .resp_dz(resp_dz), .resp_err(resp_err),
        .div_N(div_N), .div_D(div_D),
        .div_in_valid(div_in_valid), .div_rst(div_rst),
        .div_ready(dv_ready), .div_out_valid(dv_ov), .div_out(dv_out)
    );

    // Pack per-requester operands onto the flat buses
    always_comb begin
        req_N = '0;
        req_D = '0;
        for (int i = 0; i < NR; i++) begin
            req_N[i*DW +: DW] = rq_n[i];
            req_D[i*DW +: DW] = rq_d[i];
        end
    end

    function automatic logic [DW-1:0] stub_q(input logic [DW-1:0] n, input logic [DW-1:0] d);
        longint nn;
        longint dd;
        nn = longint'($signed(n));
        dd = longint'($signed(d));
        return 32'((nn <<< 28) / dd);
    endfunction

    // Divider stub: sync reset, random latency, holds DONE until reset
    always @(posedge clk) begin
        if (div_rst) begin
            dv_ready <= 1'b0;
            dv_ov    <= 1'b0;
            dv_busy  <= 1'b0;
        end else if (dv_busy) begin
            if (!stub_hang) begin
                if (dv_cnt <= 1) begin
                    dv_busy <= 1'b0;
                    dv_ov   <= 1'b1;
                    dv_out  <= stub_q(dv_n, dv_d);
                end else begin
                    dv_cnt <= dv_cnt - 1;
                end
            end
        end else if (dv_ready && div_in_valid) begin
            dv_ready <= 1'b0;
            dv_busy  <= 1'b1;
            dv_cnt   <= int'($urandom_range(8, 3));
            dv_n     <= div_N;
            dv_d     <= div_D;
        end else if (!dv_ov && !dv_ready) begin
            dv_ready <= 1'b1;
        end
    end

    task automatic check(input string name, input bit ok, input longint act, input longint req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic bit near(input logic [DW-1:0] a, input logic [DW-1:0] e);
        longint diff;
        diff = longint'($signed(a)) - longint'($signed(e));
        return (diff <= 16) && (diff >= -16);
    endfunction

    // Reference quotient: N/D scaled to Q4.28 with real arithmetic
    function automatic logic [DW-1:0] ref_q(input logic [DW-1:0] n, input logic [DW-1:0] d);
        real r;
        r = (real'($signed(n)) / real'($signed(d))) * 268435456.0;
        return 32'($rtoi(r));
    endfunction

    function automatic int rr_pick(input logic [NR-1:0] v, input int ptr);
        for (int k = 0; k < NR; k++) begin
            if (v[(ptr + k) % NR]) return (ptr + k) % NR;
        end
        return ptr;
    endfunction

    function automatic int ops_pending();
        int s;
        s = 0;
        for (int i = 0; i < NR; i++) s += op_q[i].size();
        return s;
    endfunction

    // Requester and response-side driver
    initial begin
        for (int i = 0; i < NR; i++) begin
            rq_n[i] = '0;
            rq_d[i] = '0;
        end
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NR; i++) begin
                if (hs_last[i] || !req_valid[i]) begin
                    if (op_q[i].size() > 0) begin
                        op_t op;
                        op = op_q[i].pop_front();
                        rq_n[i] = op.n;
                        rq_d[i] = op.d;
                        req_valid[i] = 1'b1;
                    end else begin
                        req_valid[i] = 1'b0;
                    end
                end
            end
            resp_ready = hold_bp ? 1'b0 : (rand_bp ? ($urandom_range(3, 0) != 0) : 1'b1);
        end
    end

    // Monitor: checks grants against the round-robin rule, scores responses
    initial begin
        int       model_ptr;
        bit       stall_prev;
        exp_t     prev;
        model_ptr  = 0;
        stall_prev = 1'b0;
        prev       = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                model_ptr  = 0;
                hs_last    = '0;
                stall_prev = 1'b0;
            end else begin
                hs_last = req_valid & req_ready;
                if (div_in_valid) n_issue++;
                if (div_rst) n_flush++;
                if (req_ready != '0) begin
                    int   g;
                    int   eg;
                    exp_t e;
                    g = 0;
                    for (int i = 0; i < NR; i++) if (req_ready[i]) g = i;
                    eg = rr_pick(req_valid, model_ptr);
                    check("grant_onehot", $onehot(req_ready) && req_valid[g], longint'(req_ready), longint'(req_valid));
                    check("grant_rr", g == eg, g, eg);
                    grant_log.push_back(g);
                    model_ptr = (g + 1) % NR;
                    e.id  = IW'(g);
                    e.dz  = (rq_d[g] == '0);
                    e.err = 1'b0;
                    if (e.dz) begin
                        e.data = rq_n[g][DW-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
                    end else if (stub_hang) begin
                        e.data = '0;
                        e.err  = 1'b1;
                    end else begin
                        e.data = ref_q(rq_n[g], rq_d[g]);
                    end
                    exp_q.push_back(e);
                end
                if (stall_prev) begin
                    check("resp_hold", resp_valid && resp_data == prev.data && resp_id == prev.id &&
                          resp_dz == prev.dz && resp_err == prev.err, resp_data, prev.data);
                end
                if (resp_valid && resp_ready) begin
                    if (exp_q.size() == 0) begin
                        check("resp_unexpected", 1'b0, resp_data, 0);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("resp_id", resp_id == e.id, resp_id, e.id);
                        check("resp_dz", resp_dz == e.dz, resp_dz, e.dz);
                        check("resp_err", resp_err == e.err, resp_err, e.err);
                        if (e.dz || e.err) check("resp_data_exact", resp_data == e.data, resp_data, e.data);
                        else check("resp_data", near(resp_data, e.data), resp_data, e.data);
                    end
                end
                stall_prev = resp_valid && !resp_ready;
                prev.data  = resp_data;
                prev.id    = resp_id;
                prev.dz    = resp_dz;
                prev.err   = resp_err;
            end
        end
    end

    task automatic check_reset_outputs();
        check("rst_req_ready", req_ready == '0, req_ready, 0);
        check("rst_resp_valid", resp_valid == 1'b0, resp_valid, 0);
        check("rst_resp_data", resp_data == '0, resp_data, 0);
        check("rst_resp_id", resp_id == '0, resp_id, 0);
        check("rst_resp_flags", {resp_dz, resp_err} == 2'b00, {resp_dz, resp_err}, 0);
        check("rst_div_in_valid", div_in_valid == 1'b0, div_in_valid, 0);
        check("rst_div_ops", div_N == '0 && div_D == '0, div_N, 0);
        check("rst_div_rst", div_rst == 1'b1, div_rst, 1);
    endtask

    task automatic push_op(input int i, input logic [DW-1:0] n, input logic [DW-1:0] d);
        op_t op;
        op.n = n;
        op.d = d;
        op_q[i].push_back(op);
    endtask

    task automatic wait_idle(input int budget);
        bit done;
        int c;
        done = 1'b0;
        c    = 0;
        while (!done && c < budget) begin
            @(negedge clk);
            #1;
            c++;
            done = (exp_q.size() == 0) && (ops_pending() == 0) && (req_valid == '0) && !resp_valid;
        end
        if (!done) check("idle_timeout", 1'b0, c, budget);
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_issue(input int budget);
        int c;
        c = 0;
        while (!div_in_valid && c < budget) begin
            @(negedge clk);
            c++;
        end
        if (!div_in_valid) check("issue_timeout", 1'b0, c, budget);
    endtask

    initial begin
        int            ni;
        int            nf;
        int            exp_order [5];
        logic [DW-1:0] d0;
        logic [18:0]   rn;
        logic [DW-1:0] rd;
        int            c;

        exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 2; exp_order[3] = 3; exp_order[4] = 0;

        // Reset state
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);

        // Round-robin with all requesters valid
        grant_log.delete();
        push_op(0, 32'h0001_0000, 32'h0004_0000);
        push_op(0, 32'h0001_0000, 32'h0004_0000);
        for (int i = 1; i < NR; i++) push_op(i, 32'h0001_0000, 32'h0004_0000);
        wait_idle(2000);
        check("rr_count", grant_log.size() == 5, grant_log.size(), 5);
        for (int j = 0; j < 5 && j < grant_log.size(); j++) begin
            check("rr_order", grant_log[j] == exp_order[j], grant_log[j], exp_order[j]);
        end

        // Single operation on requester 2
        ni = n_issue;
        nf = n_flush;
        push_op(2, 32'h0006_0000, 32'h0002_0000);
        wait_idle(500);
        check("single_issue_pulses", n_issue - ni == 1, n_issue - ni, 1);
        check("single_flush_pulses", n_flush - nf == 1, n_flush - nf, 1);

        // Divide-by-zero bypass
        ni = n_issue;
        nf = n_flush;
        push_op(1, 32'hFFFF_0000, 32'h0000_0000);
        wait_idle(500);
        check("dz_issue_pulses", n_issue - ni == 0, n_issue - ni, 0);
        check("dz_flush_pulses", n_flush - nf == 0, n_flush - nf, 0);

        // Negative divisor with backpressure, another requester waiting
        hold_bp = 1'b1;
        @(negedge clk);
        push_op(3, 32'h0003_0000, 32'hFFFF_0000);
        push_op(0, 32'h0001_0000, 32'h0004_0000);
        c = 0;
        while (!resp_valid && c < 200) begin
            @(negedge clk);
            c++;
        end
        d0 = resp_data;
        check("bp_resp_seen", resp_valid == 1'b1, resp_valid, 1);
        check("bp_data", near(d0, 32'hD000_0000), d0, 32'hD000_0000);
        repeat (10) begin
            @(negedge clk);
            check("bp_hold", resp_valid && resp_data == d0 && req_ready == '0, resp_data, d0);
        end
        hold_bp = 1'b0;
        wait_idle(1000);

        // Reset while the divider is busy
        push_op(1, 32'h0002_0000, 32'h0001_0000);
        wait_issue(200);
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check_reset_outputs();
        end
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_no_resp", resp_valid == 1'b0, resp_valid, 0);
        push_op(1, 32'h0005_0000, 32'h0002_0000);
        wait_idle(500);

        // Randomized traffic with random backpressure
        rand_bp = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            rn = 19'($urandom);
            rd = $urandom;
            if ($urandom_range(7, 0) == 0) rd = '0;
            else if (!rd[DW-1]) rd = rd | 32'h0001_0000;
            else rd = rd & 32'hFFFE_FFFF;
            push_op(int'($urandom_range(NR - 1, 0)), {{13{rn[18]}}, rn}, rd);
            repeat ($urandom_range(5, 0)) @(negedge clk);
        end
        wait_idle(20000);
        rand_bp = 1'b0;

`ifdef DIV_TIMEOUT_EN
        // Hanging divider: watchdog response then recovery
        stub_hang = 1'b1;
        nf = n_flush;
        @(negedge clk);
        push_op(0, 32'h0001_0000, 32'h0004_0000);
        wait_issue(200);
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!resp_valid && c < 200);
        check("to_latency", c == 65, c, 65);
        check("to_err", resp_err == 1'b1 && resp_data == '0, {resp_err, resp_data}, 33'h1_0000_0000);
        wait_idle(500);
        stub_hang = 1'b0;
        check("to_flush_pulses", n_flush - nf == 1, n_flush - nf, 1);
        push_op(2, 32'h0006_0000, 32'h0002_0000);
        wait_idle(500);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global bound on simulation time
    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "simulation time limit");
    end

endmodule
